// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: one register level per shift level, LSL/LSR/ASR/ROL with right-shift sticky bit and valid/ready back-pressure
module pipelined_barrel_shifter #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH),
  localparam int LEVELS = SHW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shift,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sticky
);
  logic adv;
  for (genvar k = 0; k < LEVELS; k++) begin : stg
    localparam int A = 1 << k;
    logic vi, sb, ms, si, so, v, st;
    logic [1:0] md;
    logic [SHW-1:k] ra;
    logic [WIDTH-1:0] x, y, d;
    if (k == 0) begin : i
      assign vi = in_valid;
      assign x  = in_data;
      assign md = in_mode;
      assign ra = in_shift;
      assign ms = in_data[WIDTH-1];
      assign si = 1'b0;
    end else begin : i
      assign vi = stg[k-1].v;
      assign x  = stg[k-1].d;
      assign md = stg[k-1].c.m;
      assign ra = stg[k-1].c.rs;
      assign ms = stg[k-1].c.msr;
      assign si = stg[k-1].st;
    end
    assign sb = ra[k];
    assign y  = !sb ? x :
                md == 2'b00 ? {x[WIDTH-1-A:0], {A{1'b0}}} :
                md == 2'b01 ? {{A{1'b0}}, x[WIDTH-1:A]} :
                md == 2'b10 ? {{A{ms}}, x[WIDTH-1:A]} :
                              {x[WIDTH-1-A:0], x[WIDTH-1:WIDTH-A]};
    // sticky only accumulates for LSR (01) and ASR (10)
    assign so = ^md & (si | (sb & |x[A-1:0]));
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v  <= 1'b0;
        d  <= '0;
        st <= 1'b0;
      end else if (adv) begin
        v  <= vi;
        d  <= y;
        st <= so;
      end
    end
    if (k < LEVELS - 1) begin : c
      logic [1:0] m;
      logic msr;
      logic [SHW-1:k+1] rs;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          m   <= '0;
          msr <= 1'b0;
          rs  <= '0;
        end else if (adv) begin
          m   <= md;
          msr <= ms;
          rs  <= ra[SHW-1:k+1];
        end
      end
    end
  end
  assign adv        = out_ready || !out_valid;
  assign in_ready   = adv;
  assign out_valid  = stg[LEVELS-1].v;
  assign out_data   = stg[LEVELS-1].d;
  assign out_sticky = stg[LEVELS-1].st;
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: scoreboard bench over WIDTH 4/8/16/32 with an arithmetic reference model
module tb_pipelined_barrel_shifter;
  localparam int NW = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic iv [NW], ir [NW], ov [NW], ordy [NW], ost [NW];
  logic [31:0] idata [NW], odata [NW];
  logic [4:0] ish [NW];
  logic [1:0] imode [NW];
  int pend [NW];
  int checks = 0, failures = 0, cyc = 0;
  bit bp = 1'b0;

  always @(posedge clk) cyc++;

  for (genvar n = 0; n < NW; n++) begin : w
    localparam int W = 4 << n;
    localparam int SH = $clog2(W);
    logic [W-1:0] od, hd;
    logic hv = 1'b0, hs = 1'b0;
    logic [W:0] e;
    logic [W:0] expq [$];
    int tq [$];
    int t, np = 0;

    pipelined_barrel_shifter #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv[n]), .in_ready(ir[n]),
      .in_data(idata[n][W-1:0]), .in_shift(ish[n][SH-1:0]), .in_mode(imode[n]),
      .out_valid(ov[n]), .out_ready(ordy[n]),
      .out_data(od), .out_sticky(ost[n])
    );
    assign odata[n] = 32'(od);
    assign pend[n] = np;

    function automatic logic [W:0] model(input logic [W-1:0] a, input int s, input logic [1:0] m);
      logic [W-1:0] r, mask;
      mask = ~({W{1'b1}} << s);
      case (m)
        2'd0: r = a << s;
        2'd1: r = a >> s;
        2'd2: r = $signed(a) >>> s;
        default: r = (a << s) | (a >> (W - s));
      endcase
      return {(m == 2'd1 || m == 2'd2) && |(a & mask), r};
    endfunction

    always @(negedge clk) begin
      if (!rst_n) begin
        expq.delete();
        tq.delete();
        hv = 1'b0;
      end else begin
        checks++;
        if (ir[n] !== (ordy[n] || !ov[n])) begin
          failures++;
          $display("FAIL w%0d in_ready act=%b exp=%b", W, ir[n], ordy[n] || !ov[n]);
        end
        if (hv) begin
          checks++;
          if (ov[n] !== 1'b1 || od !== hd || ost[n] !== hs) begin
            failures++;
            $display("FAIL w%0d stall_hold act=%b/%h/%b exp=1/%h/%b", W, ov[n], od, ost[n], hd, hs);
          end
        end
        hv = ov[n] && !ordy[n];
        hd = od;
        hs = ost[n];
        if (iv[n] && ir[n]) begin
          expq.push_back(model(idata[n][W-1:0], int'(ish[n][SH-1:0]), imode[n]));
          tq.push_back(bp ? -1 : cyc);
        end
        if (ov[n] && ordy[n]) begin
          checks++;
          if (expq.size() == 0) begin
            failures++;
            $display("FAIL w%0d spurious_beat act=%h exp=none", W, od);
          end else begin
            e = expq.pop_front();
            t = tq.pop_front();
            if ({ost[n], od} !== e) begin
              failures++;
              $display("FAIL w%0d result act=%b/%h exp=%b/%h", W, ost[n], od, e[W], e[W-1:0]);
            end
            if (t >= 0) begin
              checks++;
              if (cyc - t != SH) begin
                failures++;
                $display("FAIL w%0d latency act=%0d exp=%0d", W, cyc - t, SH);
              end
            end
          end
        end
      end
      np = expq.size();
    end
  end

  initial begin
    for (int n = 0; n < NW; n++) ordy[n] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int n = 0; n < NW; n++) ordy[n] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic send(input int n, input logic [31:0] d, input int s, input logic [1:0] m);
    bit a;
    int k = 0;
    iv[n] = 1'b1;
    idata[n] = d;
    ish[n] = 5'(s);
    imode[n] = m;
    do begin
      @(negedge clk);
      a = ir[n];
      @(posedge clk);
      #1;
      k++;
    end while (!a && k < 200);
    if (!a) begin
      checks++;
      failures++;
      $display("FAIL w%0d accept_timeout act=%0d exp<200", 4 << n, k);
    end
    iv[n] = 1'b0;
    idata[n] = $urandom;
    ish[n] = 5'($urandom);
    imode[n] = 2'($urandom);
  endtask

  task automatic drain(input int n);
    int k = 0;
    while (pend[n] != 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    chk("drain_pending", 32'(pend[n]), 32'd0);
    #1;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    bit stale;
    rst_n = 1'b0;
    for (int n = 0; n < NW; n++) begin
      iv[n] = 1'b0;
      idata[n] = '0;
      ish[n] = '0;
      imode[n] = '0;
    end
    idle(2);
    for (int n = 0; n < NW; n++) begin
      chk("rst_out_valid", 32'(ov[n]), 32'd0);
      chk("rst_out_data", odata[n], 32'd0);
      chk("rst_out_sticky", 32'(ost[n]), 32'd0);
      chk("rst_in_ready", 32'(ir[n]), 32'd1);
    end
    rst_n = 1'b1;
    send(2, 32'h00F1, 4, 2'b00);
    send(2, 32'h8001, 1, 2'b11);
    send(2, 32'h8001, 3, 2'b10);
    send(2, 32'h8000, 15, 2'b01);
    send(2, 32'h00FF, 0, 2'b01);
    send(2, 32'hFFFF, 0, 2'b10);
    send(2, 32'hA5A5, 8, 2'b11);
    drain(2);
    bp = 1'b1;
    for (int i = 0; i < 24; i++) send(2, $urandom, $urandom_range(0, 15), 2'($urandom));
    drain(2);
    @(posedge clk);
    #3 bp = 1'b0;
    idle(2);
    for (int i = 0; i < 3; i++) send(2, $urandom | 32'h8000, i + 1, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ov[2]), 32'd0);
    chk("midrst_out_data", odata[2], 32'd0);
    chk("midrst_out_sticky", 32'(ost[2]), 32'd0);
    chk("midrst_in_ready", 32'(ir[2]), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      stale |= ov[2];
    end
    chk("no_stale_after_reset", 32'(stale), 32'd0);
    idle(1);
    for (int d = 0; d < 16; d++)
      for (int s = 0; s < 4; s++)
        for (int m = 0; m < 4; m++) send(0, 32'(d), s, 2'(m));
    drain(0);
    for (int d = 0; d < 256; d++)
      for (int s = 0; s < 8; s++)
        for (int m = 0; m < 4; m++) send(1, 32'(d), s, 2'(m));
    drain(1);
    for (int i = 0; i < 200; i++) send(2, $urandom, $urandom_range(0, 15), 2'($urandom));
    drain(2);
    for (int i = 0; i < 400; i++) send(3, $urandom, $urandom_range(0, 31), 2'($urandom));
    drain(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
